// File: rtl/npu_sched_pkg.sv
// Shared definitions for the NPU schedule sequencer: micro-op field layout,
// FSM state encoding and default buffer depth.
package npu_sched_pkg;

    localparam int SCHED_DEPTH_DEF = 64;
    localparam int OP_W            = 16;

    localparam int BIT_END       = 15;
    localparam int BIT_IN_RD     = 14;
    localparam int BIT_SIG_RD    = 13;
    localparam int BIT_SIG_WR    = 12;
    localparam int BIT_OUT_WR    = 11;
    localparam int BIT_PE_WR     = 10;
    localparam int BIT_ACC_RD    = 9;
    localparam int BIT_ACC_WR    = 8;
    localparam int BIT_SIG_IN_EN = 7;
    localparam int PE_LSB        = 4;
    localparam int PE_W          = 3;
    localparam int FUNC_LSB      = 2;
    localparam int FUNC_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/npu_sched_ram.sv
// Schedule buffer: synchronous write, asynchronous read, contents not reset.
module npu_sched_ram
    import npu_sched_pkg::*;
#(
    parameter int DEPTH  = SCHED_DEPTH_DEF,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OP_W-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OP_W-1:0]   rdata
);

    logic [OP_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/npu_sched_sequencer.sv
// Schedule-replay controller: stores micro-ops during config and replays one
// per cycle as datapath strobes, stalling on input-empty / output-full.
module npu_sched_sequencer
    import npu_sched_pkg::*;
#(
    parameter int SCHED_DEPTH = SCHED_DEPTH_DEF,
    parameter int ADDR_W      = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sched_write_en,
    input  logic [15:0]       sched_din,
    input  logic              sched_clear,
    input  logic              compute_en,
    input  logic              input_fifo_empty,
    input  logic              output_fifo_full,
    output logic              input_fifo_read_en,
    output logic              sigmoid_fifo_read_en,
    output logic              sigmoid_fifo_write_en,
    output logic              output_fifo_write_en,
    output logic              pe_write_en,
    output logic              acc_fifo_read_en,
    output logic              acc_fifo_write_en,
    output logic              sigmoid_input_en,
    output logic [2:0]        pe_select,
    output logic [2:0]        sigmoid_sel_pe,
    output logic [1:0]        sigmoid_func_sel,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sched_count,
    output logic              cfg_err
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(SCHED_DEPTH);
    localparam logic [ADDR_W:0] ONE_COUNT  = (ADDR_W+1)'(1);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              cfg_err_q;
    logic [OP_W-1:0]   op;
    logic [1:0]        unused_reserved;
    logic              in_idle, in_run, stall, fire, last_op, full, wr_accept;

    npu_sched_ram #(.DEPTH(SCHED_DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (CLK),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (sched_din),
        .raddr (rd_ptr_q),
        .rdata (op)
    );

    assign unused_reserved = op[1:0];
    assign in_idle   = (state_q == ST_IDLE);
    assign in_run    = (state_q == ST_RUN);
    assign full      = (count_q == FULL_COUNT);
    assign stall     = (op[BIT_IN_RD] & input_fifo_empty) | (op[BIT_OUT_WR] & output_fifo_full);
    assign fire      = in_run & ~stall;
    assign last_op   = op[BIT_END] | ({1'b0, rd_ptr_q} == (count_q - ONE_COUNT));
    assign wr_accept = RST & ~sched_clear & in_idle & sched_write_en & ~full;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (compute_en && count_q != '0) state_d = ST_RUN;
            ST_RUN:  if (fire && last_op) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A pass ends only through DONE, sched_clear or reset; compute_en is ignored once running.
    always_ff @(posedge CLK) begin
        if (!RST || sched_clear) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + ONE_COUNT;
            end
            if (sched_write_en && (!in_idle || full))
                cfg_err_q <= 1'b1;
            if (in_idle && compute_en && count_q == '0)
                cfg_err_q <= 1'b1;
            if (in_idle || state_q == ST_DONE)
                rd_ptr_q <= '0;
            else if (fire)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign input_fifo_read_en    = fire & op[BIT_IN_RD];
    assign sigmoid_fifo_read_en  = fire & op[BIT_SIG_RD];
    assign sigmoid_fifo_write_en = fire & op[BIT_SIG_WR];
    assign output_fifo_write_en  = fire & op[BIT_OUT_WR];
    assign pe_write_en           = fire & op[BIT_PE_WR];
    assign acc_fifo_read_en      = fire & op[BIT_ACC_RD];
    assign acc_fifo_write_en     = fire & op[BIT_ACC_WR];
    assign sigmoid_input_en      = fire & op[BIT_SIG_IN_EN];
    assign pe_select             = in_run ? op[PE_LSB +: PE_W] : '0;
    assign sigmoid_sel_pe        = in_run ? op[PE_LSB +: PE_W] : '0;
    assign sigmoid_func_sel      = in_run ? op[FUNC_LSB +: FUNC_W] : '0;
    assign busy                  = in_run;
    assign done                  = (state_q == ST_DONE);
    assign sched_count           = count_q;
    assign cfg_err               = cfg_err_q;

endmodule

// File: tb/tb_npu_sched_sequencer.sv
// Directed bench for npu_sched_sequencer: loaded micro-ops are queued as
// expectations and popped as the sequencer replays them.
module tb_npu_sched_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        sched_write_en = 1'b0;
    logic [15:0] sched_din = '0;
    logic        sched_clear = 1'b0;
    logic        compute_en = 1'b0;
    logic        input_fifo_empty = 1'b0;
    logic        output_fifo_full = 1'b0;
    logic        input_fifo_read_en, sigmoid_fifo_read_en, sigmoid_fifo_write_en;
    logic        output_fifo_write_en, pe_write_en, acc_fifo_read_en, acc_fifo_write_en;
    logic        sigmoid_input_en;
    logic [2:0]  pe_select, sigmoid_sel_pe;
    logic [1:0]  sigmoid_func_sel;
    logic        busy, done, cfg_err;
    logic [6:0]  sched_count;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q [$];

    npu_sched_sequencer dut (
        .CLK(CLK), .RST(RST),
        .sched_write_en(sched_write_en), .sched_din(sched_din),
        .sched_clear(sched_clear), .compute_en(compute_en),
        .input_fifo_empty(input_fifo_empty), .output_fifo_full(output_fifo_full),
        .input_fifo_read_en(input_fifo_read_en),
        .sigmoid_fifo_read_en(sigmoid_fifo_read_en),
        .sigmoid_fifo_write_en(sigmoid_fifo_write_en),
        .output_fifo_write_en(output_fifo_write_en),
        .pe_write_en(pe_write_en),
        .acc_fifo_read_en(acc_fifo_read_en),
        .acc_fifo_write_en(acc_fifo_write_en),
        .sigmoid_input_en(sigmoid_input_en),
        .pe_select(pe_select), .sigmoid_sel_pe(sigmoid_sel_pe),
        .sigmoid_func_sel(sigmoid_func_sel),
        .busy(busy), .done(done), .sched_count(sched_count), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] strobes();
        return {input_fifo_read_en, sigmoid_fifo_read_en, sigmoid_fifo_write_en,
                output_fifo_write_en, pe_write_en, acc_fifo_read_en,
                acc_fifo_write_en, sigmoid_input_en};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] w, input bit push);
        sched_write_en = 1'b1;
        sched_din      = w;
        if (push) exp_q.push_back(w);
        tick();
        sched_write_en = 1'b0;
    endtask

    task automatic clearSchedule();
        sched_clear = 1'b1;
        tick();
        sched_clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic startPass();
        compute_en = 1'b1;
        tick();
        compute_en = 1'b0;
    endtask

    // One popped expectation against the current (unstalled) cycle.
    task automatic checkOp(input string tag);
        logic [15:0] w;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            w = exp_q.pop_front();
            checkOutput({tag, "_strobes"}, 32'(strobes()), 32'({w[14], w[13], w[12], w[11], w[10], w[9], w[8], w[7]}));
            checkOutput({tag, "_pe_sel"}, 32'(pe_select), 32'(w[6:4]));
            checkOutput({tag, "_sig_pe"}, 32'(sigmoid_sel_pe), 32'(w[6:4]));
            checkOutput({tag, "_func"}, 32'(sigmoid_func_sel), 32'(w[3:2]));
        end
    endtask

    task automatic runPass(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            checkOp(tag);
            tick();
        end
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [15:0] w;

        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_count", 32'(sched_count), 32'd0);
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("rst_strobes", 32'(strobes()), 32'd0);
        RST = 1'b1;
        tick();

        // Three-op pass: pe_wr pe0, pe_wr pe1, out_wr|END
        applyStimulus(16'h0408, 1'b1);
        applyStimulus(16'h0410, 1'b1);
        applyStimulus(16'h8800, 1'b1);
        checkOutput("load3_count", 32'(sched_count), 32'd3);
        startPass();
        runPass(3, "pass3");

        // Overfill: 65 writes into a 64-entry buffer, then replay all 64
        clearSchedule();
        for (int i = 1; i <= 65; i++) begin
            w = 16'(i * 40503 + 4660);
            w[15] = 1'b0;
            applyStimulus(w, i <= 64);
        end
        checkOutput("full_count", 32'(sched_count), 32'd64);
        checkOutput("full_cfg_err", 32'(cfg_err), 32'd1);
        startPass();
        runPass(64, "pass64");

        // in_rd stalled by input_fifo_empty for four cycles
        clearSchedule();
        applyStimulus(16'hC000, 1'b1);
        input_fifo_empty = 1'b1;
        startPass();
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_in_strobes", 32'(strobes()), 32'd0);
            checkOutput("stall_in_busy", 32'(busy), 32'd1);
            checkOutput("stall_in_done", 32'(done), 32'd0);
            tick();
        end
        input_fifo_empty = 1'b0;
        #1;
        checkOp("stall_in_fire");
        tick();
        checkOutput("stall_in_done_after", 32'(done), 32'd1);
        tick();

        // out_wr stalled by output_fifo_full, aborted by sched_clear
        clearSchedule();
        applyStimulus(16'h8800, 1'b1);
        output_fifo_full = 1'b1;
        startPass();
        for (int i = 0; i < 2; i++) begin
            checkOutput("stall_out_strobes", 32'(strobes()), 32'd0);
            checkOutput("stall_out_busy", 32'(busy), 32'd1);
            tick();
        end
        clearSchedule();
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_count", 32'(sched_count), 32'd0);
        tick();
        checkOutput("abort_done_later", 32'(done), 32'd0);
        output_fifo_full = 1'b0;

        // Start with empty schedule, then a write during RUN
        checkOutput("empty_start_err_before", 32'(cfg_err), 32'd0);
        startPass();
        checkOutput("empty_start_busy", 32'(busy), 32'd0);
        checkOutput("empty_start_err", 32'(cfg_err), 32'd1);
        clearSchedule();
        applyStimulus(16'h0424, 1'b1);
        applyStimulus(16'h8598, 1'b1);
        startPass();
        checkOp("busy_wr_op0");
        sched_write_en = 1'b1;
        sched_din      = 16'hFFFF;
        tick();
        sched_write_en = 1'b0;
        checkOutput("busy_wr_err", 32'(cfg_err), 32'd1);
        checkOutput("busy_wr_count", 32'(sched_count), 32'd2);
        checkOp("busy_wr_op1");
        tick();
        checkOutput("busy_wr_done", 32'(done), 32'd1);
        tick();

        // Reset asserted mid-RUN with cfg_err set
        clearSchedule();
        startPass();
        checkOutput("pre_rst_err", 32'(cfg_err), 32'd1);
        applyStimulus(16'h0400, 1'b0);
        applyStimulus(16'h0410, 1'b0);
        applyStimulus(16'h8800, 1'b0);
        startPass();
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        RST = 1'b0;
        tick();
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_count", 32'(sched_count), 32'd0);
        checkOutput("midrst_err", 32'(cfg_err), 32'd0);
        checkOutput("midrst_strobes", 32'(strobes()), 32'd0);
        checkOutput("midrst_pe", 32'({pe_select, sigmoid_sel_pe, sigmoid_func_sel}), 32'd0);
        RST = 1'b1;
        tick();
        checkOutput("postrst_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
